// File: rtl/audio_pkg.sv
// audio_pkg: widths, clocking constants and types shared between the sample
// pacer and the downstream PWM controller.
package audio_pkg;

    // Sample and duty-threshold widths (threshold matches the PWM controller input)
    localparam int SAMPLE_W = 8;
    localparam int THRESH_W = 27;

    // System clock and the default pacing divider: 100 MHz / 2268 is about 44.1 kHz
    localparam int CLK_HZ   = 100_000_000;
    localparam int TICK_DIV = 2268;

    // Default placement of the sample inside the threshold word
    localparam int THRESH_SHIFT = 18;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [THRESH_W-1:0] thresh_t;

endpackage : audio_pkg

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous FIFO with registered occupancy.
// Pushes into a full FIFO and pops from an empty FIFO are ignored, so a
// same-cycle push into an empty FIFO is never visible to a pop.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (level_r == LW'(DEPTH));
    assign empty  = (level_r == LW'(0));
    assign level  = level_r;
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage, pointers (wrapping modulo DEPTH) and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule : sample_fifo

// File: rtl/pwm_sample_pacer.sv
// pwm_sample_pacer: buffers incoming audio samples and releases one per
// sample-rate tick as a scaled duty threshold for the PWM controller.
// Optional build macro PWM_PACER_VOLUME_EN adds a 3-bit volume input that
// right-shifts the popped threshold (0 = full scale, 7 = divide by 128).
module pwm_sample_pacer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W     = audio_pkg::SAMPLE_W,
    parameter int THRESH_W     = audio_pkg::THRESH_W,
    parameter int THRESH_SHIFT = audio_pkg::THRESH_SHIFT,
    parameter int TICK_DIV     = audio_pkg::TICK_DIV,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [SAMPLE_W-1:0]      sample_data,
    input  logic                     sample_valid,
    output logic                     sample_ready,
`ifdef PWM_PACER_VOLUME_EN
    input  logic [2:0]               volume,
`endif
    output logic [THRESH_W-1:0]      pwm_thresh,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0]    tick_cnt_r;
    logic                tick_s;
    logic                ready_en_r;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [SAMPLE_W-1:0] fifo_head_s;
    logic [THRESH_W-1:0] scaled_s;
    logic [THRESH_W-1:0] pwm_thresh_r;
    logic                underrun_r;

    // Tick fires in the last cycle of each divider period, only while enabled
    assign tick_s = enable && (tick_cnt_r == CNT_W'(TICK_DIV - 1));

    // Ready is held low through reset and the first cycle after it
    assign sample_ready = ready_en_r && !fifo_full_s;
    assign push_s       = sample_valid && sample_ready;
    assign pop_s        = tick_s && !fifo_empty_s;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (sample_data),
        .pop       (pop_s),
        .level     (fifo_level),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

    // Place the head sample into the threshold word, then apply attenuation
    always_comb begin
        scaled_s = THRESH_W'(fifo_head_s) << THRESH_SHIFT;
`ifdef PWM_PACER_VOLUME_EN
        scaled_s = scaled_s >> volume;
`else
        scaled_s = scaled_s;
`endif
    end

    // Sample-rate divider; parked at zero while playback is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (!enable || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    // Releases sample_ready one cycle after reset is removed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Output threshold register and one-cycle underrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_thresh_r <= '0;
            underrun_r   <= 1'b0;
        end else begin
            underrun_r <= tick_s && fifo_empty_s;
            if (!enable) begin
                pwm_thresh_r <= '0;
            end else if (pop_s) begin
                pwm_thresh_r <= scaled_s;
            end else begin
                pwm_thresh_r <= pwm_thresh_r;
            end
        end
    end

    assign pwm_thresh = pwm_thresh_r;
    assign underrun   = underrun_r;

endmodule : pwm_sample_pacer

// File: tb/tb_pwm_sample_pacer.sv
// Directed testbench for pwm_sample_pacer with TICK_DIV=4, DEPTH=4.
module tb_pwm_sample_pacer;

    localparam int SW = 8;
    localparam int TW = 27;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [SW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [TW-1:0] pwm_thresh;
    logic [LW-1:0] fifo_level;
    logic          underrun;
`ifdef PWM_PACER_VOLUME_EN
    logic [2:0]    volume = 3'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pwm_sample_pacer #(
        .SAMPLE_W     (8),
        .THRESH_W     (27),
        .THRESH_SHIFT (18),
        .TICK_DIV     (4),
        .DEPTH        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
`ifdef PWM_PACER_VOLUME_EN
        .volume       (volume),
`endif
        .pwm_thresh   (pwm_thresh),
        .fifo_level   (fifo_level),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs and checks happen 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        enable = 1'b0;
        sample_valid = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic push_one(input logic [SW-1:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        push_one(8'h11); push_one(8'h22); push_one(8'h33); push_one(8'h44);
        enable = 1'b1;
        step(4);
        check("rst_pre_thresh", 32'(pwm_thresh), 32'h0044_0000);
        check("rst_pre_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        #1;
        check("rst_thresh", 32'(pwm_thresh), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ready_low", 32'(sample_ready), 32'd0);
        enable = 1'b0;
        step(1);
        rst = 1'b0;
        #1;
        check("rst_ready_release", 32'(sample_ready), 32'd0);
        step(1);
        check("rst_ready_after", 32'(sample_ready), 32'd1);
    endtask

    task automatic test_pacing();
        reset_dut();
        push_one(8'h80);
        push_one(8'hFF);
        check("pace_level2", 32'(fifo_level), 32'd2);
        enable = 1'b1;
        step(3);
        check("pace_before_tick", 32'(pwm_thresh), 32'd0);
        step(1);
        check("pace_first", 32'(pwm_thresh), 32'h0200_0000);
        check("pace_level1", 32'(fifo_level), 32'd1);
        step(3);
        check("pace_hold", 32'(pwm_thresh), 32'h0200_0000);
        step(1);
        check("pace_second", 32'(pwm_thresh), 32'h03FC_0000);
        check("pace_no_underrun", 32'(underrun), 32'd0);
        enable = 1'b0;
        step(1);
        check("pace_disable_zero", 32'(pwm_thresh), 32'd0);
    endtask

    task automatic test_backpressure();
        int acc;
        reset_dut();
        acc = 0;
        sample_data  = 8'hA0;
        sample_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (sample_ready) begin
                acc++;
            end
            step(1);
            if (acc > 0) begin
                sample_data = 8'hA0 + 8'(acc);
            end
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(sample_ready), 32'd0);
        check("bp_level_full", 32'(fifo_level), 32'd4);
        enable = 1'b1;
        step(3);
        check("bp_ready_still_low", 32'(sample_ready), 32'd0);
        step(1);
        check("bp_ready_after_pop", 32'(sample_ready), 32'd1);
        check("bp_first_out", 32'(pwm_thresh), 32'h0280_0000);
        step(1);
        check("bp_refilled", 32'(fifo_level), 32'd4);
        check("bp_ready_low_again", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_underrun();
        reset_dut();
        push_one(8'h10);
        enable = 1'b1;
        step(4);
        check("ur_thresh", 32'(pwm_thresh), 32'h0040_0000);
        check("ur_none_yet", 32'(underrun), 32'd0);
        step(3);
        check("ur_before", 32'(underrun), 32'd0);
        step(1);
        check("ur_pulse", 32'(underrun), 32'd1);
        check("ur_hold_thresh", 32'(pwm_thresh), 32'h0040_0000);
        step(1);
        check("ur_pulse_end", 32'(underrun), 32'd0);
        enable = 1'b0;
    endtask

    task automatic test_empty_push_on_tick();
        reset_dut();
        enable = 1'b1;
        step(3);
        sample_data  = 8'h01;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        check("ept_underrun", 32'(underrun), 32'd1);
        check("ept_level", 32'(fifo_level), 32'd1);
        check("ept_thresh_zero", 32'(pwm_thresh), 32'd0);
        step(3);
        check("ept_wait", 32'(pwm_thresh), 32'd0);
        step(1);
        check("ept_popped", 32'(pwm_thresh), 32'h0004_0000);
        check("ept_level_empty", 32'(fifo_level), 32'd0);
        check("ept_no_underrun", 32'(underrun), 32'd0);
        enable = 1'b0;
    endtask

`ifdef PWM_PACER_VOLUME_EN
    task automatic test_volume();
        reset_dut();
        volume = 3'd2;
        push_one(8'hFF);
        enable = 1'b1;
        step(4);
        check("vol_thresh", 32'(pwm_thresh), 32'h00FF_0000);
        enable = 1'b0;
        step(1);
        check("vol_disable_zero", 32'(pwm_thresh), 32'd0);
        volume = 3'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_pacing();
        test_backpressure();
        test_underrun();
        test_empty_push_on_tick();
`ifdef PWM_PACER_VOLUME_EN
        test_volume();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pwm_sample_pacer

// File: doc/pwm_sample_pacer.md
Name: pwm_sample_pacer

Overview:
Upstream feeder for the PWM amplifier controller. Accepts 8-bit audio samples over a valid/ready handshake and buffers them in a small FIFO. Pops one sample per sample-rate tick, scales it into the 27-bit duty threshold, and drives pwm_thresh directly into the PWM controller. Pacing is set by a clock divider, so the PWM stage sees a steady, rate-locked threshold stream.

Parameters:
SAMPLE_W, 8, sample width in bits.
THRESH_W, 27, output threshold width; matches the PWM controller threshold input.
THRESH_SHIFT, 18, left shift from sample to threshold; SAMPLE_W+THRESH_SHIFT must be <= THRESH_W.
TICK_DIV, 2268, clk cycles per sample; 100 MHz / 2268 ≈ 44.1 kHz. Must be >= 2.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  playback enable
sample_data  input  SAMPLE_W  incoming sample, unsigned, 0 = silence floor
sample_valid  input  1  sample_data valid
sample_ready  output  1  block can accept a sample this cycle
pwm_thresh  output  THRESH_W  duty threshold to PWM controller
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
underrun  output  1  one-cycle pulse: tick occurred with FIFO empty

Behaviour:
- Reset (async, rst=1):
  - pwm_thresh=0, underrun=0, fifo_level=0.
  - FIFO empty, tick counter=0.
  - sample_ready=1 one cycle after rst deasserts; it is 0 while rst is high.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Internal tick is high in the cycle where count==TICK_DIV-1.
  - While enable=0, the counter is held at 0 and no tick occurs.
- Push:
  - Occurs when sample_valid && sample_ready.
  - sample_ready = (fifo_level != DEPTH), decoded from registered occupancy.
  - A producer may hold sample_valid indefinitely; data must stay stable until accepted.
- Pop:
  - On tick with fifo_level>0, the head is removed.
  - Next cycle, pwm_thresh = zero-extended {sample, THRESH_SHIFT zeros}.
  - Latency: tick to pwm_thresh update is 1 cycle.
- Underrun:
  - On tick with fifo_level==0, pwm_thresh holds its previous value.
  - underrun pulses high for exactly 1 cycle, the cycle after the tick.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - If the FIFO is full, ready=0, so a pop frees a slot that becomes available next cycle.
  - If the FIFO is empty, a same-cycle push is not visible to the pop. The result is an underrun, and the pushed sample is popped at the next tick.
- enable falling:
  - pwm_thresh is forced to 0 the next cycle.
  - FIFO contents are retained and pushes continue until full.
- enable rising:
  - The first tick occurs TICK_DIV cycles later.
- Mid-operation rst: all state is cleared immediately, including FIFO contents; no partial output.
- Pointers wrap modulo DEPTH. Occupancy uses $clog2(DEPTH)+1 bits so that full and empty are distinct.

Optional Feature:
- Macro PWM_PACER_VOLUME_EN.
- When defined:
  - Adds input port volume[2:0].
  - The popped threshold is right-shifted by volume before registering: 0 = full scale, 7 = attenuated by 128.
  - volume is sampled only in the tick cycle.
- When undefined:
  - No volume port and no shifter; behaviour is identical to volume=0.

Decomposition:
- Package audio_pkg:
  - THRESH_W=27 and SAMPLE_W=8.
  - CLK_HZ=100_000_000 and default TICK_DIV, shared with the PWM controller counter constants.
  - typedef sample_t (logic [SAMPLE_W-1:0]) and typedef thresh_t (logic [THRESH_W-1:0]).
- Sub-module sample_fifo:
  - Parameterised DEPTH/width; synchronous push/pop; async rst.
  - Outputs level, full, empty, head.
- Tick counter, scaling and output register stay in the top.

Test Plan:
- Common settings: TICK_DIV=4, DEPTH=4 unless stated.
1. Reset: assert rst mid-run with 3 samples queued -> pwm_thresh=0, fifo_level=0, underrun=0 immediately; sample_ready=1 one cycle after release.
2. Basic pacing: push 0x80, then 0xFF; enable=1 -> pwm_thresh=0x0200_0000 one cycle after the first tick, then 0x03FC_0000 exactly 4 cycles later.
3. Full backpressure: sample_valid held high with enable=0 -> 4 accepted, then sample_ready=0, fifo_level=4. Enable -> ready returns 1 the cycle after the first pop.
4. Underrun: one sample 0x10 queued, enable=1 -> pwm_thresh=0x0040_0000. At the next tick, underrun pulses 1 cycle and pwm_thresh stays 0x0040_0000.
5. Empty push on tick: push 0x01 in the tick cycle with FIFO empty -> underrun pulse; next tick yields pwm_thresh=0x0004_0000.
6. With PWM_PACER_VOLUME_EN, volume=2: sample 0xFF -> pwm_thresh=0x00FF_0000. Dropping enable -> pwm_thresh=0 the next cycle.
